// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_controller
//  Purpose  : Round-robin N-phase junction controller with actuated green,
//             latched pedestrian calls and flashing-yellow night mode.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_controller #(
    parameter int NUM_PHASES    = 4,
    parameter int TIMER_W       = 8,
    parameter int GREEN_MIN     = 20,
    parameter int GREEN_MAX     = 100,
    parameter int YELLOW_TIME   = 30,
    parameter int ALLRED_TIME   = 10,
    parameter int PED_WALK_TIME = 15,
    parameter int BLINK_HALF    = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          night_mode,
    input  logic [NUM_PHASES-1:0]         sensor,
    input  logic [NUM_PHASES-1:0]         ped_req,
    output logic [3*NUM_PHASES-1:0]       lights,
    output logic [NUM_PHASES-1:0]         walk,
    output logic [NUM_PHASES-1:0]         ped_pending,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase
);

    localparam int AW = $clog2(NUM_PHASES);
    localparam logic [TIMER_W-1:0] C_GREEN_MIN_M1 = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] C_GREEN_MAX_M1 = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] C_YELLOW_M1    = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] C_ALLRED_M1    = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] C_BLINK_M1     = TIMER_W'(BLINK_HALF - 1);
    localparam logic [TIMER_W-1:0] C_WALK         = TIMER_W'(PED_WALK_TIME);
    localparam logic [AW-1:0]      C_LAST_PHASE   = AW'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_BLINK  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
    logic [AW-1:0]         r_phase, w_phase_nxt;
    logic                  r_toggle, w_toggle_nxt;
    logic                  r_walk_en, w_walk_en_nxt;
    logic [NUM_PHASES-1:0] r_ped, w_ped_nxt;

    logic [NUM_PHASES-1:0] w_demand;
    logic [NUM_PHASES-1:0] w_active_mask;
    logic                  w_other_demand;
    logic [AW-1:0]         w_phase_inc;
    logic [AW-1:0]         w_pick_hi, w_pick_lo, w_search_phase;
    logic                  w_hit_hi, w_hit_lo;
    logic                  w_enter_green;
    logic                  w_walk_on;

    assign w_demand       = sensor | r_ped;
    assign w_active_mask  = NUM_PHASES'(1) << r_phase;
    assign w_other_demand = |(w_demand & ~w_active_mask);
    assign w_phase_inc    = (r_phase == C_LAST_PHASE) ? '0 : r_phase + 1'b1;

    // Lowest demanding phase above the active one wins; otherwise wrap to
    // the lowest demanding phase at or below it.
    always_comb begin
        w_hit_hi  = 1'b0;
        w_hit_lo  = 1'b0;
        w_pick_hi = '0;
        w_pick_lo = '0;
        for (int p = NUM_PHASES - 1; p >= 0; p--) begin
            if (w_demand[p]) begin
                if (AW'(p) > r_phase) begin
                    w_hit_hi  = 1'b1;
                    w_pick_hi = AW'(p);
                end else begin
                    w_hit_lo  = 1'b1;
                    w_pick_lo = AW'(p);
                end
            end
        end
        w_search_phase = w_hit_hi ? w_pick_hi : (w_hit_lo ? w_pick_lo : w_phase_inc);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_toggle_nxt  = r_toggle;
        w_walk_en_nxt = r_walk_en;
        w_timer_nxt   = r_timer + 1'b1;
        w_enter_green = 1'b0;
        case (r_state)
            S_GREEN: begin
                if (r_timer == C_GREEN_MAX_M1)
                    w_timer_nxt = r_timer;
                if (night_mode ||
                    (w_other_demand &&
                     ((r_timer >= C_GREEN_MIN_M1 && !sensor[r_phase]) ||
                      r_timer >= C_GREEN_MAX_M1))) begin
                    w_state_nxt   = S_YELLOW;
                    w_timer_nxt   = '0;
                    w_walk_en_nxt = 1'b0;
                end
            end
            S_YELLOW: begin
                if (r_timer == C_YELLOW_M1) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = '0;
                end
            end
            S_ALLRED: begin
                if (r_timer == C_ALLRED_M1) begin
                    w_timer_nxt = '0;
                    if (night_mode) begin
                        w_state_nxt  = S_BLINK;
                        w_toggle_nxt = 1'b1;
                        w_phase_nxt  = C_LAST_PHASE;
                    end else begin
                        w_state_nxt   = S_GREEN;
                        w_phase_nxt   = w_search_phase;
                        w_walk_en_nxt = r_ped[w_search_phase];
                        w_enter_green = 1'b1;
                    end
                end
            end
            default: begin
                // Parking on the last phase makes the exit clearance search from phase 0.
                if (!night_mode) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = '0;
                end else if (r_timer == C_BLINK_M1) begin
                    w_toggle_nxt = ~r_toggle;
                    w_timer_nxt  = '0;
                end
            end
        endcase
        w_ped_nxt = (r_ped & ~(w_enter_green ? (NUM_PHASES'(1) << w_search_phase)
                                             : {NUM_PHASES{1'b0}})) | ped_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_GREEN;
            r_timer   <= '0;
            r_phase   <= '0;
            r_toggle  <= 1'b0;
            r_walk_en <= 1'b0;
            r_ped     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_phase   <= w_phase_nxt;
            r_toggle  <= w_toggle_nxt;
            r_walk_en <= w_walk_en_nxt;
            r_ped     <= w_ped_nxt;
        end
    end

    assign w_walk_on    = (r_state == S_GREEN) && r_walk_en && (r_timer < C_WALK);
    assign ped_pending  = r_ped;
    assign active_phase = r_phase;

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_lamp
        logic w_is_active;
        assign w_is_active = (r_phase == AW'(p));
        assign lights[3*p +: 3] =
            (r_state == S_GREEN)  ? (w_is_active ? 3'b100 : 3'b001) :
            (r_state == S_YELLOW) ? (w_is_active ? 3'b010 : 3'b001) :
            (r_state == S_ALLRED) ? 3'b001 :
            (r_toggle ? 3'b010 : 3'b000);
        assign walk[p] = w_walk_on && w_is_active;
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_controller
//  Purpose  : Directed self-checking bench for traffic_phase_controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_controller;

    localparam logic [11:0] C_P0G  = 12'h24C;
    localparam logic [11:0] C_P0Y  = 12'h24A;
    localparam logic [11:0] C_AR   = 12'h249;
    localparam logic [11:0] C_P1G  = 12'h261;
    localparam logic [11:0] C_P2G  = 12'h309;
    localparam logic [11:0] C_P3G  = 12'h849;
    localparam logic [11:0] C_BON  = 12'h492;
    localparam logic [11:0] C_BOFF = 12'h000;

    logic        clk;
    logic        rst;
    logic        night_mode;
    logic [3:0]  sensor;
    logic [3:0]  ped_req;
    logic [11:0] lights;
    logic [3:0]  walk;
    logic [3:0]  ped_pending;
    logic [1:0]  active_phase;

    int n_checks = 0;
    int n_fail   = 0;
    int len;

    traffic_phase_controller dut (
        .clk          (clk),
        .rst          (rst),
        .night_mode   (night_mode),
        .sensor       (sensor),
        .ped_req      (ped_req),
        .lights       (lights),
        .walk         (walk),
        .ped_pending  (ped_pending),
        .active_phase (active_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] sens);
        rst        = 1'b1;
        night_mode = 1'b0;
        ped_req    = 4'b0;
        sensor     = sens;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts consecutive negedges on which lights hold pat, bounded by limit.
    task automatic len_lights(input logic [11:0] pat, input int limit, output int n);
        n = 0;
        while (lights === pat && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic len_walk(input logic [3:0] pat, input int limit, output int n);
        n = 0;
        while (walk === pat && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; night_mode = 1'b0; sensor = 4'b0; ped_req = 4'b0;

        // Reset state and idle rest in phase 0
        do_reset(4'b0000);
        check("reset_lights", 32'(lights), 32'(C_P0G));
        check("reset_walk", 32'(walk), 32'h0);
        check("reset_pending", 32'(ped_pending), 32'h0);
        check("reset_phase", 32'(active_phase), 32'h0);
        for (int k = 0; k < 5; k++) begin
            repeat (100) @(negedge clk);
            check("idle_lights", 32'(lights), 32'(C_P0G));
        end
        check("idle_walk", 32'(walk), 32'h0);
        check("idle_phase", 32'(active_phase), 32'h0);
        // Rested timer is past min green, so demand elsewhere ends green at once
        sensor = 4'b0100;
        len_lights(C_P0G, 200, len);
        check("rest_gap_green_len", 32'(len), 32'd1);

        // Gap-out at min green: sensor[0]=0, demand on phase 2
        do_reset(4'b0100);
        len_lights(C_P0G, 200, len);
        check("gap_green_len", 32'(len), 32'd20);
        len_lights(C_P0Y, 200, len);
        check("yellow_len", 32'(len), 32'd30);
        len_lights(C_AR, 200, len);
        check("allred_len", 32'(len), 32'd10);
        check("p2_green", 32'(lights), 32'(C_P2G));
        check("p2_phase", 32'(active_phase), 32'd2);

        // Max-out with sensor[0] held
        do_reset(4'b0101);
        len_lights(C_P0G, 200, len);
        check("max_green_len", 32'(len), 32'd100);

        // Pedestrian call on phase 1
        do_reset(4'b0000);
        ped_req = 4'b0010;
        @(negedge clk);
        ped_req = 4'b0000;
        check("ped_latched", 32'(ped_pending), 32'b0010);
        len_lights(C_P0G, 200, len);
        check("ped_green_len", 32'(len), 32'd19);
        len_lights(C_P0Y, 200, len);
        len_lights(C_AR, 200, len);
        check("p1_green", 32'(lights), 32'(C_P1G));
        check("p1_pending_clr", 32'(ped_pending), 32'h0);
        len_walk(4'b0010, 200, len);
        check("walk_len", 32'(len), 32'd15);
        check("walk_off_green", 32'(lights), 32'(C_P1G));

        // Pedestrian request on the green-entry edge: set wins over clear
        do_reset(4'b0000);
        ped_req = 4'b0010;
        @(negedge clk);
        ped_req = 4'b0000;
        len_lights(C_P0G, 200, len);
        len_lights(C_P0Y, 200, len);
        repeat (9) @(negedge clk);
        check("pre_entry_allred", 32'(lights), 32'(C_AR));
        ped_req = 4'b0010;
        @(negedge clk);
        ped_req = 4'b0000;
        check("entry_p1_green", 32'(lights), 32'(C_P1G));
        check("entry_pending_kept", 32'(ped_pending), 32'b0010);
        len_walk(4'b0010, 200, len);
        check("entry_walk_len", 32'(len), 32'd15);

        // Night mode
        do_reset(4'b0001);
        repeat (5) @(negedge clk);
        night_mode = 1'b1;
        @(negedge clk);
        len_lights(C_P0Y, 200, len);
        check("night_yellow_len", 32'(len), 32'd30);
        len_lights(C_AR, 200, len);
        check("night_allred_len", 32'(len), 32'd10);
        check("blink_phase", 32'(active_phase), 32'd3);
        len_lights(C_BON, 200, len);
        check("blink_on_len", 32'(len), 32'd10);
        check("blink_off", 32'(lights), 32'(C_BOFF));
        check("blink_walk", 32'(walk), 32'h0);
        ped_req = 4'b0100;
        @(negedge clk);
        ped_req = 4'b0000;
        check("blink_ped", 32'(ped_pending), 32'b0100);
        len_lights(C_BOFF, 200, len);
        check("blink_off_len", 32'(len), 32'd9);
        check("blink_on_again", 32'(lights), 32'(C_BON));
        night_mode = 1'b0;
        @(negedge clk);
        len_lights(C_AR, 200, len);
        check("exit_allred_len", 32'(len), 32'd10);
        check("exit_p0_green", 32'(lights), 32'(C_P0G));
        check("exit_phase", 32'(active_phase), 32'd0);

        // Reset during a walk on phase 3
        do_reset(4'b0000);
        ped_req = 4'b1000;
        @(negedge clk);
        ped_req = 4'b0000;
        len_lights(C_P0G, 200, len);
        len_lights(C_P0Y, 200, len);
        len_lights(C_AR, 200, len);
        check("p3_green", 32'(lights), 32'(C_P3G));
        repeat (3) @(negedge clk);
        check("p3_walk", 32'(walk), 32'b1000);
        ped_req = 4'b0100;
        @(negedge clk);
        ped_req = 4'b0000;
        check("p3_pending", 32'(ped_pending), 32'b0100);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_lights", 32'(lights), 32'(C_P0G));
        check("mid_rst_walk", 32'(walk), 32'h0);
        check("mid_rst_pending", 32'(ped_pending), 32'h0);
        check("mid_rst_phase", 32'(active_phase), 32'h0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
